md_sequencer: RTL and testbench

Multiply/divide sequencer for the 5-stage MIPS pipeline. Sits beside the E-stage ALU and owns the HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E, runs multi-cycle operations with a busy counter, and raises a stall toward D for any multiply/divide-class instruction while an operation is in flight.

---
 rtl/md_pkg.sv | 38 +++
 rtl/md_arith.sv | 55 +++++
 rtl/md_sequencer.sv | 107 ++++++++++
 tb/tb_md_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, state encoding,
// default latencies. Divide ops are only recognised when MD_DIV_EN is defined.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(input logic [3:0] op);
`ifdef MD_DIV_EN
    return (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == 4'hf) && 1'b0;
`endif
  endfunction

  // Ops that occupy the sequencer for a multi-cycle busy period.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi, lo}. Non-arithmetic ops and
// divide-by-zero pass the current HI/LO through. Divider present only with MD_DIV_EN.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MD_DIV_EN
  logic [31:0] mag_a, mag_b, uq, ur, q_s, r_s, udq, udr;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    uq    = 32'd0;
    ur    = 32'd0;
    udq   = 32'd0;
    udr   = 32'd0;
    if (b != 32'd0) begin
      uq  = mag_a / mag_b;
      ur  = mag_a % mag_b;
      udq = a / b;
      udr = a % b;
    end
    q_s = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    r_s = a[31] ? (~ur + 32'd1) : ur;
  end
`endif

  always_comb begin
    result = {cur_hi, cur_lo};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
`ifdef MD_DIV_EN
      OP_DIV:   if (b != 32'd0) result = {r_s, q_s};
      OP_DIVU:  if (b != 32'd0) result = {udr, udq};
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: multi-cycle busy counter, D-stage stall,
// MFHI/MFLO read port. DIV/DIVU are supported only when MD_DIV_EN is defined.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_a,
  input  logic [31:0] E_b,
  input  logic        D_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] E_rdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic [63:0]   arith_res;
  logic          long_op;

  assign long_op = is_long_op(E_op);

  md_arith u_arith (
    .op     (E_op),
    .a      (E_a),
    .b      (E_b),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .result (arith_res)
  );

  // Starts are only accepted in IDLE; anything arriving while BUSY is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      ST_IDLE: begin
        if (E_start) begin
          if (long_op) begin
            {phi_d, plo_d} = arith_res;
            cnt_d   = is_div_op(E_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = ST_BUSY;
          end else if (E_op == OP_MTHI) begin
            hi_d = E_a;
          end else if (E_op == OP_MTLO) begin
            lo_d = E_a;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  always_comb begin
    E_rdata = 32'd0;
    if (E_start && (E_op == OP_MFHI)) E_rdata = hi_q;
    if (E_start && (E_op == OP_MFLO)) E_rdata = lo_q;
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = D_md & (busy | (E_start & long_op));
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer; expectations adapt to whether MD_DIV_EN is defined.
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        E_start;
  logic [3:0]  E_op;
  logic [31:0] E_a;
  logic [31:0] E_b;
  logic        D_md;
  logic        busy;
  logic        stall;
  logic [31:0] E_rdata;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_q[$];

  md_sequencer #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .E_start (E_start),
    .E_op    (E_op),
    .E_a     (E_a),
    .E_b     (E_b),
    .D_md    (D_md),
    .busy    (busy),
    .stall   (stall),
    .E_rdata (E_rdata),
    .HI      (HI),
    .LO      (LO)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int op_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MULT_N;
    if (DIV_EN && (op == 4'd3 || op == 4'd4)) return DIV_N;
    return 0;
  endfunction

  function automatic logic [63:0] model_next(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    res = {hi, lo};
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: if (DIV_EN && b != 32'd0) begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      4'd4: if (DIV_EN && b != 32'd0) res = {a % b, a / b};
      4'd7: res = {a, lo};
      4'd8: res = {hi, a};
      default: ;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [3:0] op);
    if (op == 4'd5) return m_hi;
    if (op == 4'd6) return m_lo;
    return 32'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic dmd);
    E_start = st;
    E_op    = op;
    E_a     = a;
    E_b     = b;
    D_md    = dmd;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected %h", HI, 32'd0); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected %h", LO, 32'd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (E_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", E_rdata); end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    logic [3:0]  ops[2];
    logic        dmds[2];
    logic [63:0] want[2];
    logic        exp_busy;
    logic [63:0] exp_hl;
    ops  = '{4'd1, 4'd2};
    dmds = '{1'b1, 1'b0};
    want = '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE};
    for (int t = 0; t < 2; t++) begin
      next_cycle();
      drive(1'b1, ops[t], 32'hFFFFFFFF, 32'd2, dmds[t]);
      checks++; if (stall !== dmds[t]) begin failures++; $display("FAIL mult_start_stall[%0d]: got %b expected %b", t, stall, dmds[t]); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_start_busy[%0d]: got %b expected 0", t, busy); end
      for (int i = 1; i <= MULT_N + 1; i++) begin
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, dmds[t]);
        exp_busy = (i <= MULT_N);
        exp_hl   = exp_busy ? {m_hi, m_lo} : want[t];
        checks++; if (busy !== exp_busy) begin failures++; $display("FAIL mult_busy[%0d] cyc %0d: got %b expected %b", t, i, busy, exp_busy); end
        checks++; if (stall !== (dmds[t] & exp_busy)) begin failures++; $display("FAIL mult_stall[%0d] cyc %0d: got %b expected %b", t, i, stall, dmds[t] & exp_busy); end
        checks++; if ({HI, LO} !== exp_hl) begin failures++; $display("FAIL mult_hilo[%0d] cyc %0d: got %h expected %h", t, i, {HI, LO}, exp_hl); end
      end
      {m_hi, m_lo} = want[t];
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops[4];
    logic [31:0] as[4];
    logic [31:0] bs[4];
    logic [63:0] want[4];
    logic [63:0] exp_res;
    logic        exp_busy;
    logic [63:0] exp_hl;
    int          n;
    ops  = '{4'd3, 4'd4, 4'd3, 4'd3};
    as   = '{32'hFFFFFFF9, 32'd7, 32'd1234, 32'h80000000};
    bs   = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    want = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003, 64'h00000001_00000003,
             64'h00000000_80000000};
    n = DIV_EN ? DIV_N : 0;
    for (int t = 0; t < 4; t++) begin
      exp_res = DIV_EN ? want[t] : {m_hi, m_lo};
      next_cycle();
      drive(1'b1, ops[t], as[t], bs[t], 1'b1);
      checks++; if (stall !== DIV_EN) begin failures++; $display("FAIL div_start_stall[%0d]: got %b expected %b", t, stall, DIV_EN); end
      for (int i = 1; i <= DIV_N + 1; i++) begin
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        exp_busy = (i <= n);
        exp_hl   = exp_busy ? {m_hi, m_lo} : exp_res;
        checks++; if (busy !== exp_busy) begin failures++; $display("FAIL div_busy[%0d] cyc %0d: got %b expected %b", t, i, busy, exp_busy); end
        checks++; if (stall !== exp_busy) begin failures++; $display("FAIL div_stall[%0d] cyc %0d: got %b expected %b", t, i, stall, exp_busy); end
        checks++; if ({HI, LO} !== exp_hl) begin failures++; $display("FAIL div_hilo[%0d] cyc %0d: got %h expected %h", t, i, {HI, LO}, exp_hl); end
      end
      {m_hi, m_lo} = exp_res;
    end
  endtask

  task automatic test_move();
    next_cycle();
    drive(1'b1, 4'd7, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    next_cycle();
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    checks++; if (E_rdata !== 32'h00001234) begin failures++; $display("FAIL mfhi_after_mthi: got %h expected %h", E_rdata, 32'h00001234); end
    checks++; if (LO !== m_lo) begin failures++; $display("FAIL mthi_lo_kept: got %h expected %h", LO, m_lo); end
    m_hi = 32'h00001234;
    drive(1'b1, 4'd8, 32'hCAFE0001, 32'd0, 1'b0);
    next_cycle();
    drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    checks++; if (E_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL mflo_after_mtlo: got %h expected %h", E_rdata, 32'hCAFE0001); end
    m_lo = 32'hCAFE0001;
    drive(1'b1, 4'd12, 32'h5555AAAA, 32'd3, 1'b1);
    checks++; if (E_rdata !== 32'd0) begin failures++; $display("FAIL undef_op_rdata: got %h expected 0", E_rdata); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL undef_op_stall: got %b expected 0", stall); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checks++; if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL undef_op_hilo: got %h expected %h", {HI, LO}, {m_hi, m_lo}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL undef_op_busy: got %b expected 0", busy); end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] exp_hl;
    logic        exp_busy;
    exp_hl = 64'h00000000_0000000F;
    next_cycle();
    drive(1'b1, 4'd1, 32'd3, 32'd5, 1'b1);
    for (int i = 1; i <= MULT_N + 2; i++) begin
      next_cycle();
      if (i == 2)           drive(1'b1, 4'd7, 32'hDEADBEEF, 32'd0, 1'b1);
      else if (i == MULT_N) drive(1'b1, 4'd1, 32'd7, 32'd7, 1'b1);
      else                  drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      exp_busy = (i <= MULT_N);
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL ignore_busy cyc %0d: got %b expected %b", i, busy, exp_busy); end
      checks++; if (stall !== exp_busy) begin failures++; $display("FAIL ignore_stall cyc %0d: got %b expected %b", i, stall, exp_busy); end
      checks++; if ({HI, LO} !== (exp_busy ? {m_hi, m_lo} : exp_hl)) begin failures++; $display("FAIL ignore_hilo cyc %0d: got %h expected %h", i, {HI, LO}, exp_busy ? {m_hi, m_lo} : exp_hl); end
    end
    {m_hi, m_lo} = exp_hl;
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] op;
    op = DIV_EN ? 4'd3 : 4'd1;
    next_cycle();
    drive(1'b1, op, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL midrst_hilo: got %h expected 0", {HI, LO}); end
    next_cycle();
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < DIV_N + 2; i++) next_cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_after_busy: got %b expected 0", busy); end
    checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL midrst_after_hilo: got %h expected 0", {HI, LO}); end
  endtask

  task automatic test_random();
    logic [31:0] corners[6];
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        dmd;
    logic [63:0] e;
    int          n;
    corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd7};
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 9));
      if (op == 4'd9) op = 4'($urandom_range(9, 15));
      a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      dmd = 1'($urandom_range(0, 1));
      n   = op_cycles(op);
      exp_q.push_back(model_next(op, a, b, m_hi, m_lo));
      next_cycle();
      drive(1'b1, op, a, b, dmd);
      checks++; if (stall !== (dmd & (n > 0))) begin failures++; $display("FAIL rnd_start_stall #%0d op %0d: got %b expected %b", k, op, stall, dmd & (n > 0)); end
      checks++; if (E_rdata !== model_rdata(op)) begin failures++; $display("FAIL rnd_rdata #%0d op %0d: got %h expected %h", k, op, E_rdata, model_rdata(op)); end
      for (int i = 1; i <= n + 1; i++) begin
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, dmd);
        checks++; if (busy !== (i <= n)) begin failures++; $display("FAIL rnd_busy #%0d cyc %0d: got %b expected %b", k, i, busy, i <= n); end
        if (i == n + 1) begin
          e = exp_q.pop_front();
          checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL rnd_result #%0d op %0d a %h b %h: got %h expected %h", k, op, a, b, {HI, LO}, e); end
          {m_hi, m_lo} = e;
        end else begin
          checks++; if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL rnd_hold #%0d cyc %0d: got %h expected %h", k, i, {HI, LO}, {m_hi, m_lo}); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    E_start  = 1'b0;
    E_op     = 4'd0;
    E_a      = 32'd0;
    E_b      = 32'd0;
    D_md     = 1'b0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    #2;
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
